// File: rtl/axi_lite_pkg.sv
// axi_lite_pkg: AXI4-Lite response codes and the channel FSM state types
// shared by the memory responder and its storage array.
package axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_EXEC,
        W_RESP
    } wr_state_t;

    typedef enum logic {
        R_IDLE,
        R_DATA
    } rd_state_t;

endpackage

// File: rtl/axil_mem_array.sv
// axil_mem_array: byte-enabled word array, one synchronous write port and
// one combinational read port (a same-edge read sees the pre-write word).
module axil_mem_array
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    localparam int IDX_W     = $clog2(DEPTH),
    localparam int BYTES     = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [BYTES-1:0]      wstrb,
    input  logic [IDX_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < BYTES; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/axi_lite_mem_slave.sv
// axi_lite_mem_slave: AXI4-Lite responder backed by a DEPTH-word array.
// Define AXIL_MEM_DECERR_EN to answer out-of-range addresses with DECERR.
module axi_lite_mem_slave
    import axi_lite_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 16
) (
    input  logic                    s0_axi_aclk,
    input  logic                    s0_axi_aresetn,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_awaddr,
    input  logic                    s0_axi_awvalid,
    output logic                    s0_axi_awready,
    input  logic [DATA_WIDTH-1:0]   s0_axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_axi_wstrb,
    input  logic                    s0_axi_wvalid,
    output logic                    s0_axi_wready,
    output logic [1:0]              s0_axi_bresp,
    output logic                    s0_axi_bvalid,
    input  logic                    s0_axi_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_axi_araddr,
    input  logic                    s0_axi_arvalid,
    output logic                    s0_axi_arready,
    output logic [DATA_WIDTH-1:0]   s0_axi_rdata,
    output logic [1:0]              s0_axi_rresp,
    output logic                    s0_axi_rvalid,
    input  logic                    s0_axi_rready
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(BYTES);
    localparam int IDX_W     = $clog2(DEPTH);
    localparam int MEM_BYTES = DEPTH * BYTES;
    localparam int AW1       = ADDR_WIDTH + 1;

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic                  aw_captured;
    logic                  w_captured;
    logic [IDX_W-1:0]      wr_idx;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [BYTES-1:0]      wr_strb;
    logic                  wr_oor;
    logic [DATA_WIDTH-1:0] mem_rdata;
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  aw_next;
    logic                  w_next;
    logic                  mem_we;
    logic                  aw_oor;
    logic                  ar_oor;
    logic                  unused_addr_bits;

`ifdef AXIL_MEM_DECERR_EN
    localparam logic [ADDR_WIDTH:0] LIMIT = AW1'(MEM_BYTES);
    assign aw_oor = {1'b0, s0_axi_awaddr} >= LIMIT;
    assign ar_oor = {1'b0, s0_axi_araddr} >= LIMIT;
`else
    assign aw_oor = 1'b0;
    assign ar_oor = 1'b0;
`endif

    // Byte-offset bits (and, without range checking, the upper bits) are ignored.
    assign unused_addr_bits = ^{s0_axi_awaddr, s0_axi_araddr};

    assign aw_hs   = s0_axi_awvalid && s0_axi_awready;
    assign w_hs    = s0_axi_wvalid && s0_axi_wready;
    assign ar_hs   = s0_axi_arvalid && s0_axi_arready;
    assign aw_next = aw_captured || aw_hs;
    assign w_next  = w_captured || w_hs;
    assign mem_we  = (wr_state == W_EXEC) && !wr_oor && s0_axi_aresetn;

    axil_mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (s0_axi_aclk),
        .we    (mem_we),
        .waddr (wr_idx),
        .wdata (wr_data),
        .wstrb (wr_strb),
        .raddr (s0_axi_araddr[OFF_W +: IDX_W]),
        .rdata (mem_rdata)
    );

    always_ff @(posedge s0_axi_aclk) begin
        if (!s0_axi_aresetn) begin
            wr_state       <= W_IDLE;
            aw_captured    <= 1'b0;
            w_captured     <= 1'b0;
            wr_oor         <= 1'b0;
            s0_axi_awready <= 1'b0;
            s0_axi_wready  <= 1'b0;
            s0_axi_bvalid  <= 1'b0;
            s0_axi_bresp   <= RESP_OKAY;
        end else begin
            unique case (wr_state)
                W_IDLE: begin
                    if (aw_hs) begin
                        wr_idx <= s0_axi_awaddr[OFF_W +: IDX_W];
                        wr_oor <= aw_oor;
                    end
                    if (w_hs) begin
                        wr_data <= s0_axi_wdata;
                        wr_strb <= s0_axi_wstrb;
                    end
                    aw_captured <= aw_next;
                    w_captured  <= w_next;
                    if (aw_next && w_next) begin
                        wr_state       <= W_EXEC;
                        s0_axi_awready <= 1'b0;
                        s0_axi_wready  <= 1'b0;
                    end else begin
                        s0_axi_awready <= !aw_next;
                        s0_axi_wready  <= !w_next;
                    end
                end
                W_EXEC: begin
                    s0_axi_bvalid <= 1'b1;
                    s0_axi_bresp  <= wr_oor ? RESP_DECERR : RESP_OKAY;
                    wr_state      <= W_RESP;
                end
                W_RESP: begin
                    if (s0_axi_bready) begin
                        s0_axi_bvalid  <= 1'b0;
                        s0_axi_bresp   <= RESP_OKAY;
                        aw_captured    <= 1'b0;
                        w_captured     <= 1'b0;
                        s0_axi_awready <= 1'b1;
                        s0_axi_wready  <= 1'b1;
                        wr_state       <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge s0_axi_aclk) begin
        if (!s0_axi_aresetn) begin
            rd_state       <= R_IDLE;
            s0_axi_arready <= 1'b0;
            s0_axi_rvalid  <= 1'b0;
            s0_axi_rresp   <= RESP_OKAY;
            s0_axi_rdata   <= '0;
        end else begin
            unique case (rd_state)
                R_IDLE: begin
                    if (ar_hs) begin
                        s0_axi_rdata   <= ar_oor ? '0 : mem_rdata;
                        s0_axi_rresp   <= ar_oor ? RESP_DECERR : RESP_OKAY;
                        s0_axi_rvalid  <= 1'b1;
                        s0_axi_arready <= 1'b0;
                        rd_state       <= R_DATA;
                    end else begin
                        s0_axi_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (s0_axi_rready) begin
                        s0_axi_rvalid  <= 1'b0;
                        s0_axi_rresp   <= RESP_OKAY;
                        s0_axi_arready <= 1'b1;
                        rd_state       <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_mem_slave.sv
// tb_axi_lite_mem_slave: directed AXI4-Lite traffic against a transaction-level
// memory model; one negedge monitor checks every response the DUT produces.
module tb_axi_lite_mem_slave;

    logic        clk;
    logic        aresetn;
    logic [7:0]  awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [7:0]  araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int vectors     = 0;
    int miscompares = 0;

`ifdef AXIL_MEM_DECERR_EN
    localparam bit DECERR_ON = 1'b1;
`else
    localparam bit DECERR_ON = 1'b0;
`endif

    axi_lite_mem_slave #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (8),
        .DEPTH      (16)
    ) dut (
        .s0_axi_aclk    (clk),
        .s0_axi_aresetn (aresetn),
        .s0_axi_awaddr  (awaddr),
        .s0_axi_awvalid (awvalid),
        .s0_axi_awready (awready),
        .s0_axi_wdata   (wdata),
        .s0_axi_wstrb   (wstrb),
        .s0_axi_wvalid  (wvalid),
        .s0_axi_wready  (wready),
        .s0_axi_bresp   (bresp),
        .s0_axi_bvalid  (bvalid),
        .s0_axi_bready  (bready),
        .s0_axi_araddr  (araddr),
        .s0_axi_arvalid (arvalid),
        .s0_axi_arready (arready),
        .s0_axi_rdata   (rdata),
        .s0_axi_rresp   (rresp),
        .s0_axi_rvalid  (rvalid),
        .s0_axi_rready  (rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference memory: 16 words, 64 bytes in range.
    logic [31:0] mdl [16];

    function automatic logic oor(input logic [7:0] a);
        return DECERR_ON && (a >= 8'h40);
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        return oor(a) ? 32'h0 : mdl[a[5:2]];
    endfunction

    function automatic logic [1:0] model_resp(input logic [7:0] a);
        return oor(a) ? 2'b11 : 2'b00;
    endfunction

    logic rst_at_edge = 1'b0;
    always @(posedge clk) rst_at_edge <= !aresetn;

    int          cyc       = 0;
    logic        rst_prev  = 1'b0;
    logic        have_aw   = 1'b0;
    logic        have_w    = 1'b0;
    logic        wr_armed  = 1'b0;
    int          b_due     = 0;
    logic [7:0]  m_addr    = '0;
    logic [31:0] m_data    = '0;
    logic [3:0]  m_strb    = '0;
    logic        b_hold    = 1'b0;
    logic [1:0]  b_held    = '0;
    logic        r_wait    = 1'b0;
    int          r_due     = 0;
    logic [31:0] r_exp     = '0;
    logic [1:0]  r_exp_rsp = '0;
    logic        r_hold    = 1'b0;
    logic [31:0] r_held    = '0;
    logic [1:0]  r_held_rs = '0;

    // Handshakes seen at a negedge complete on the following posedge. A write
    // takes effect in the model at the negedge its response first appears, so a
    // read whose address was accepted on the commit edge still sees old data.
    initial begin
        logic b_new;
        logic r_new;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst_at_edge) begin
                check("rst_awready", awready, 0);
                check("rst_wready", wready, 0);
                check("rst_arready", arready, 0);
                check("rst_bvalid", bvalid, 0);
                check("rst_rvalid", rvalid, 0);
                check("rst_bresp", bresp, 0);
                check("rst_rresp", rresp, 0);
                check("rst_rdata", rdata, 0);
                have_aw  = 1'b0;
                have_w   = 1'b0;
                wr_armed = 1'b0;
                b_hold   = 1'b0;
                r_wait   = 1'b0;
                r_hold   = 1'b0;
                rst_prev = 1'b1;
            end else if (aresetn) begin
                if (rst_prev) begin
                    check("post_rst_awready", awready, 1);
                    check("post_rst_wready", wready, 1);
                    check("post_rst_arready", arready, 1);
                end
                rst_prev = 1'b0;

                b_new = bvalid && !b_hold;
                if (b_hold) begin
                    check("b_hold_valid", bvalid, 1);
                    check("b_hold_resp", bresp, b_held);
                end
                if (b_new) begin
                    check("b_expected", wr_armed, 1);
                    if (wr_armed) begin
                        check("b_latency", cyc, b_due);
                        check("bresp", bresp, model_resp(m_addr));
                        if (!oor(m_addr)) begin
                            for (int i = 0; i < 4; i++) begin
                                if (m_strb[i]) mdl[m_addr[5:2]][i*8 +: 8] = m_data[i*8 +: 8];
                            end
                        end
                    end
                    wr_armed = 1'b0;
                    have_aw  = 1'b0;
                    have_w   = 1'b0;
                end else if (wr_armed && cyc == b_due) begin
                    check("bvalid_rise", bvalid, 1);
                end
                if (bvalid) check("aw_w_blocked", {awready, wready}, 0);
                b_hold = bvalid && !bready;
                b_held = bresp;

                r_new = rvalid && !r_hold;
                if (r_hold) begin
                    check("r_hold_valid", rvalid, 1);
                    check("r_hold_data", rdata, r_held);
                    check("r_hold_resp", rresp, r_held_rs);
                end
                if (r_new) begin
                    check("r_expected", r_wait, 1);
                    if (r_wait) begin
                        check("r_latency", cyc, r_due);
                        check("rdata", rdata, r_exp);
                        check("rresp", rresp, r_exp_rsp);
                    end
                    r_wait = 1'b0;
                end else if (r_wait && cyc == r_due) begin
                    check("rvalid_rise", rvalid, 1);
                end
                if (rvalid) check("ar_blocked", arready, 0);
                r_hold    = rvalid && !rready;
                r_held    = rdata;
                r_held_rs = rresp;

                if (awvalid && awready) begin
                    have_aw = 1'b1;
                    m_addr  = awaddr;
                end
                if (wvalid && wready) begin
                    have_w = 1'b1;
                    m_data = wdata;
                    m_strb = wstrb;
                end
                if (have_aw && have_w && !wr_armed) begin
                    wr_armed = 1'b1;
                    b_due    = cyc + 2;
                end
                if (arvalid && arready) begin
                    r_wait    = 1'b1;
                    r_due     = cyc + 1;
                    r_exp     = model_read(araddr);
                    r_exp_rsp = model_resp(araddr);
                end
            end
        end
    end

    task automatic wait_bvalid();
        int n;
        n = 0;
        @(negedge clk);
        while (!bvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bvalid_timeout", bvalid, 1);
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input bit hold, output logic [1:0] resp);
        logic aw_go;
        logic w_go;
        int   n;
        awaddr  = a;
        wdata   = d;
        wstrb   = s;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = !hold;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            @(negedge clk);
            aw_go = awvalid && awready;
            w_go  = wvalid && wready;
            @(posedge clk);
            #1;
            if (aw_go) awvalid = 1'b0;
            if (w_go) wvalid = 1'b0;
            n++;
        end
        check("wr_accept", {awvalid, wvalid}, 0);
        awvalid = 1'b0;
        wvalid  = 1'b0;
        wait_bvalid();
        resp = bresp;
        if (!hold) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
        logic go;
        int   n;
        araddr  = a;
        arvalid = 1'b1;
        rready  = 1'b1;
        n = 0;
        while (arvalid && n < 20) begin
            @(negedge clk);
            go = arready;
            @(posedge clk);
            #1;
            if (go) arvalid = 1'b0;
            n++;
        end
        check("rd_accept", arvalid, 0);
        arvalid = 1'b0;
        @(negedge clk);
        check("rd_rvalid", rvalid, 1);
        d = rdata;
        r = rresp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  resp;
        logic [31:0] d;
        logic [1:0]  r;
        for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
        aresetn = 1'b0;
        awaddr  = '0;
        awvalid = 1'b0;
        wdata   = '0;
        wstrb   = '0;
        wvalid  = 1'b0;
        bready  = 1'b0;
        araddr  = '0;
        arvalid = 1'b0;
        rready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_awready", awready, 1);
        check("rel_wready", wready, 1);
        @(posedge clk);
        #1;

        do_write(8'h04, 32'hDEADBEEF, 4'hF, 1'b0, resp);
        check("basic_bresp", resp, 2'b00);
        do_read(8'h04, d, r);
        check("basic_rdata", d, 32'hDEADBEEF);
        check("basic_rresp", r, 2'b00);

        do_write(8'h04, 32'h12345678, 4'b0011, 1'b0, resp);
        do_read(8'h04, d, r);
        check("strb_rdata", d, 32'hDEAD5678);
        do_read(8'h06, d, r);
        check("unaligned_rdata", d, 32'hDEAD5678);

        do_write(8'h04, 32'hFFFFFFFF, 4'h0, 1'b0, resp);
        check("strb0_bresp", resp, 2'b00);
        do_read(8'h04, d, r);
        check("strb0_rdata", d, 32'hDEAD5678);

        wdata  = 32'h0000AAAA;
        wstrb  = 4'hF;
        wvalid = 1'b1;
        bready = 1'b0;
        @(negedge clk);
        check("wfirst_wready", wready, 1);
        @(posedge clk);
        #1;
        wvalid = 1'b0;
        @(negedge clk);
        check("wready_dropped", wready, 0);
        check("awready_still", awready, 1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        awaddr  = 8'h08;
        awvalid = 1'b1;
        @(negedge clk);
        check("late_awready", awready, 1);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wait_bvalid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_bvalid", bvalid, 1);
            check("bp_awready", awready, 0);
        end
        @(posedge clk);
        #1;
        bready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_awready_back", awready, 1);
        @(posedge clk);
        #1;
        do_read(8'h08, d, r);
        check("wfirst_rdata", d, 32'h0000AAAA);

        do_write(8'h0C, 32'h00000011, 4'hF, 1'b0, resp);
        awaddr  = 8'h0C;
        wdata   = 32'h00000055;
        wstrb   = 4'hF;
        awvalid = 1'b1;
        wvalid  = 1'b1;
        bready  = 1'b1;
        araddr  = 8'h0C;
        rready  = 1'b1;
        @(negedge clk);
        check("coll_ready", {awready, wready}, 2'b11);
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid  = 1'b0;
        arvalid = 1'b1;
        @(negedge clk);
        check("coll_arready", arready, 1);
        @(posedge clk);
        #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("coll_rvalid", rvalid, 1);
        check("coll_old_data", rdata, 32'h00000011);
        check("coll_bvalid", bvalid, 1);
        @(posedge clk);
        #1;
        do_read(8'h0C, d, r);
        check("coll_new_data", d, 32'h00000055);

        do_write(8'h00, 32'hCAFE0000, 4'hF, 1'b0, resp);
        do_write(8'h80, 32'h00000077, 4'hF, 1'b0, resp);
`ifdef AXIL_MEM_DECERR_EN
        check("oor_bresp", resp, 2'b11);
        do_read(8'h80, d, r);
        check("oor_rdata", d, 32'h0);
        check("oor_rresp", r, 2'b11);
        do_read(8'h00, d, r);
        check("oor_mem0_kept", d, 32'hCAFE0000);
`else
        check("wrap_bresp", resp, 2'b00);
        do_read(8'h00, d, r);
        check("wrap_rdata", d, 32'h00000077);
        check("wrap_rresp", r, 2'b00);
`endif

        do_write(8'h10, 32'h99999999, 4'hF, 1'b1, resp);
        @(posedge clk);
        #1;
        aresetn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("midrst_bvalid", bvalid, 0);
        check("midrst_awready", awready, 0);
        check("midrst_rvalid", rvalid, 0);
        @(posedge clk);
        #1;
        aresetn = 1'b1;
        bready  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_awready_back", awready, 1);
        check("midrst_wready_back", wready, 1);
        @(posedge clk);
        #1;
        do_write(8'h10, 32'h0BADF00D, 4'hF, 1'b0, resp);
        check("fresh_bresp", resp, 2'b00);
        do_read(8'h10, d, r);
        check("fresh_rdata", d, 32'h0BADF00D);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
